// File: rtl/mem_port_arbiter_pkg.sv
// Shared owner-tag encoding, default read latency and byte-enable width helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_port_arbiter_pkg;

   localparam logic OWN_FETCH   = 1'b1;
   localparam logic OWN_DATA    = 1'b0;
   localparam int   DEF_MEM_LAT = 1;

   typedef struct packed {
      logic vld;
      logic is_fetch;
   } owner_t;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_owner_pipe.sv
// Read-owner tracker: LAT-deep {valid, is_fetch} shift register, async active-low clear.
// Tag appears on the outputs LAT edges after it is loaded; no backpressure, one tag per cycle.
module mem_owner_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int LAT = DEF_MEM_LAT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_vld,
   input  logic in_fetch,
   output logic out_vld,
   output logic out_fetch
);

   owner_t [LAT-1:0] stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage <= '0;
      end else begin
         stage[0] <= {in_vld, in_fetch};
         for (int i = 1; i < LAT; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign out_vld   = stage[LAT-1].vld;
   assign out_fetch = stage[LAT-1].is_fetch;

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for a single-ported memory; grant is same-cycle, read data returns MEM_LAT cycles after issue.
// Losing requester holds its request (if_stall for fetch); optional conflict counter under MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = DEF_MEM_LAT,
   parameter int MAX_STARVE = 4
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_W-1:0]     if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [DATA_W/8-1:0]   d_be,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [DATA_W-1:0]     d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_W-1:0]     d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  if_stall
`ifdef MEM_PORT_ARBITER_STATS_EN
   ,
   output logic [31:0]           conflict_cnt
`endif
);

   localparam int BE_W = be_width(DATA_W);
   localparam int SC_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(MAX_STARVE);

   logic [SC_W-1:0] starve_cnt;
   logic            fetch_force;
   logic            tag_vld;
   logic            tag_fetch;
   logic            ret_vld;
   logic            ret_fetch;

   // Data normally wins; a fetch denied MAX_STARVE cycles in a row takes the port once.
   assign fetch_force = (MAX_STARVE > 0) && (starve_cnt >= STARVE_MAX);
   assign d_gnt       = rst & d_req & ~(if_req & fetch_force);
   assign if_gnt      = rst & if_req & (~d_req | fetch_force);
   assign mem_en      = if_gnt | d_gnt;
   assign if_stall    = rst & if_req & ~if_gnt;

   always_comb begin
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (d_gnt) begin
         mem_we    = d_we;
         mem_be    = d_be;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (if_gnt) begin
         mem_be    = {BE_W{1'b1}};
         mem_addr  = if_addr;
      end
   end

   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (if_stall) begin
         if (starve_cnt < STARVE_MAX) begin
            starve_cnt <= starve_cnt + SC_W'(1);
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   // Stores carry no tag: their completion is the grant itself.
   assign tag_vld   = if_gnt | (d_gnt & ~d_we);
   assign tag_fetch = if_gnt ? OWN_FETCH : OWN_DATA;

   mem_owner_pipe #(
      .LAT (MEM_LAT)
   ) u_owner_pipe (
      .clk       (rclk),
      .rst_n     (rst),
      .in_vld    (tag_vld),
      .in_fetch  (tag_fetch),
      .out_vld   (ret_vld),
      .out_fetch (ret_fetch)
   );

   assign if_rvalid = ret_vld & (ret_fetch == OWN_FETCH);
   assign d_rvalid  = ret_vld & (ret_fetch == OWN_DATA);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid  ? mem_rdata : '0;

`ifdef MEM_PORT_ARBITER_STATS_EN
   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) begin
         conflict_cnt <= '0;
      end else if (if_req & d_req) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=3 instances share stimulus,
// vector table drives grants/memory-bus checks, a queue scoreboard checks read returns.
module tb_mem_port_arbiter;

   logic rclk = 1'b0;
   always #5 rclk = ~rclk;

   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_be;

   logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1, if_stall1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [3:0]  mem_be1;
   logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, if_stall3;
   logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic [3:0]  mem_be3;
`ifdef MEM_PORT_ARBITER_STATS_EN
   logic [31:0] cc1, cc3;
`endif

   mem_port_arbiter #(.MEM_LAT(1), .MAX_STARVE(4)) u_dut1 (
      .rclk(rclk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .if_stall(if_stall1)
`ifdef MEM_PORT_ARBITER_STATS_EN
      , .conflict_cnt(cc1)
`endif
   );

   mem_port_arbiter #(.MEM_LAT(3), .MAX_STARVE(4)) u_dut3 (
      .rclk(rclk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .if_stall(if_stall3)
`ifdef MEM_PORT_ARBITER_STATS_EN
      , .conflict_cnt(cc3)
`endif
   );

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   // Memory models: read data is a fixed function of the issued address.
   logic [31:0] p3 [2];
   always @(posedge rclk) begin
      mem_rdata1 <= (mem_en1 && !mem_we1) ? rd_of(mem_addr1) : 32'hBAD0_0001;
      p3[0]      <= (mem_en3 && !mem_we3) ? rd_of(mem_addr3) : 32'hBAD0_0003;
      p3[1]      <= p3[0];
      mem_rdata3 <= p3[1];
   end

   typedef struct {
      logic        ifr;
      logic [31:0] ia;
      logic        dr;
      logic        dwe;
      logic [3:0]  dbe;
      logic [31:0] da;
      logic [31:0] dwd;
      logic        eig;
      logic        edg;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] dat;
   } exp_t;

   exp_t  q [4][$];
   string qn [4] = '{"if1", "d1", "if3", "d3"};
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    mon_en = 1'b0;
   logic  mon_hit;
   logic  rv [4];
   logic [31:0] rd [4];
   logic  any1, any3;

   assign rv[0] = if_rvalid1;
   assign rv[1] = d_rvalid1;
   assign rv[2] = if_rvalid3;
   assign rv[3] = d_rvalid3;
   assign rd[0] = if_rdata1;
   assign rd[1] = d_rdata1;
   assign rd[2] = if_rdata3;
   assign rd[3] = d_rdata3;
   assign any1 = |{if_gnt1, if_rvalid1, if_rdata1, d_gnt1, d_rvalid1, d_rdata1, mem_en1,
                   mem_we1, mem_be1, mem_addr1, mem_wdata1, if_stall1};
   assign any3 = |{if_gnt3, if_rvalid3, if_rdata3, d_gnt3, d_rvalid3, d_rdata3, mem_en3,
                   mem_we3, mem_be3, mem_addr3, mem_wdata3, if_stall3};

   always @(posedge rclk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Every cycle each return port must match the head of its queue exactly when it is due.
   always @(negedge rclk) begin
      if (mon_en) begin
         for (int k = 0; k < 4; k++) begin
            mon_hit = (q[k].size() > 0) && (q[k][0].due == cyc);
            check({qn[k], "_rvalid"}, 128'(rv[k]), 128'(mon_hit));
            if (mon_hit) begin
               check({qn[k], "_rdata"}, 128'(rd[k]), 128'(q[k][0].dat));
               void'(q[k].pop_front());
            end else begin
               check({qn[k], "_rdata_idle"}, 128'(rd[k]), 128'(0));
            end
         end
      end
   end

   function automatic vec_t mk(input logic ifr, input logic [31:0] ia, input logic dr,
                               input logic dwe, input logic [3:0] dbe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic eig, input logic edg);
      vec_t v;
      v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe;
      v.da = da; v.dwd = dwd; v.eig = eig; v.edg = edg;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      logic [69:0] em;
      @(posedge rclk);
      #1;
      if_req = v.ifr; if_addr = v.ia; d_req = v.dr; d_we = v.dwe;
      d_be = v.dbe; d_addr = v.da; d_wdata = v.dwd;
      @(negedge rclk);
      if (v.edg)      em = {1'b1, v.dwe, v.dbe, v.da, v.dwd};
      else if (v.eig) em = {1'b1, 1'b0, 4'hF, v.ia, 32'h0};
      else            em = '0;
      check("if_gnt", 128'(if_gnt1), 128'(v.eig));
      check("d_gnt", 128'(d_gnt1), 128'(v.edg));
      check("if_stall", 128'(if_stall1), 128'(v.ifr & ~v.eig));
      check("mem_bus1", 128'({mem_en1, mem_we1, mem_be1, mem_addr1, mem_wdata1}), 128'(em));
      check("mem_bus3", 128'({mem_en3, mem_we3, mem_be3, mem_addr3, mem_wdata3}), 128'(em));
      check("gnt3", 128'({if_gnt3, d_gnt3, if_stall3}), 128'({v.eig, v.edg, v.ifr & ~v.eig}));
      if (v.eig) begin
         q[0].push_back('{due: cyc + 1, dat: rd_of(v.ia)});
         q[2].push_back('{due: cyc + 3, dat: rd_of(v.ia)});
      end
      if (v.edg && !v.dwe) begin
         q[1].push_back('{due: cyc + 1, dat: rd_of(v.da)});
         q[3].push_back('{due: cyc + 3, dat: rd_of(v.da)});
      end
   endtask

   initial begin
      vec_t tbl [$];
      vec_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // fetch stream, conflict, starvation, stores, drain
      tbl.push_back(mk(1, 32'h0,  0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 32'h4,  0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 32'h8,  0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(idle);
      tbl.push_back(mk(1, 32'h10, 1, 0, 4'hF, 32'h100, 0, 0, 1));
      tbl.push_back(mk(1, 32'h10, 0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 32'h20, 1, 0, 4'hF, 32'h300, 0, 0, 1));
      tbl.push_back(mk(1, 32'h20, 1, 0, 4'hF, 32'h304, 0, 0, 1));
      tbl.push_back(mk(1, 32'h20, 1, 0, 4'hF, 32'h308, 0, 0, 1));
      tbl.push_back(mk(1, 32'h20, 1, 0, 4'hF, 32'h30C, 0, 0, 1));
      tbl.push_back(mk(1, 32'h20, 1, 0, 4'hF, 32'h310, 0, 1, 0));
      tbl.push_back(mk(1, 32'h24, 1, 0, 4'hF, 32'h310, 0, 0, 1));
      tbl.push_back(mk(1, 32'h24, 0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 32'h0,  1, 1, 4'h3, 32'h200, 32'hDEAD_BEEF, 0, 1));
      tbl.push_back(mk(1, 32'h28, 1, 1, 4'hC, 32'h204, 32'h0BAD_F00D, 0, 1));
      tbl.push_back(mk(1, 32'h28, 1, 0, 4'hF, 32'h204, 0, 0, 1));
      tbl.push_back(mk(1, 32'h28, 0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(idle);
      tbl.push_back(idle);
      tbl.push_back(idle);

      // reset state with both requesters active
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b1;
      d_be = 4'hF; d_addr = 32'h88; d_wdata = 32'h1234_5678;
      repeat (2) @(negedge rclk);
      check("reset_outs1", 128'(any1), 128'(0));
      check("reset_outs3", 128'(any3), 128'(0));
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      rst = 1'b1;
      mon_en = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // reset asserted with a fetch in flight: its return must never appear
      apply(mk(1, 32'h40, 0, 0, 4'h0, 0, 0, 1, 0));
      @(posedge rclk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) q[k].delete();
      if_req = 1'b1; if_addr = 32'h48; d_req = 1'b1; d_we = 1'b1;
      d_be = 4'h5; d_addr = 32'h90; d_wdata = 32'hCAFE_F00D;
      @(negedge rclk);
      check("rst_mid_outs1", 128'(any1), 128'(0));
      check("rst_mid_outs3", 128'(any3), 128'(0));
      @(posedge rclk);
      #1;
      rst = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         @(negedge rclk);
         check("rst_drop", 128'({if_rvalid1, d_rvalid1, if_rvalid3, d_rvalid3}), 128'(0));
      end

      // five conflict cycles then three fetch-only cycles
      apply(mk(1, 32'h500, 1, 0, 4'hF, 32'h600, 0, 0, 1));
      apply(mk(1, 32'h500, 1, 0, 4'hF, 32'h604, 0, 0, 1));
      apply(mk(1, 32'h500, 1, 0, 4'hF, 32'h608, 0, 0, 1));
      apply(mk(1, 32'h500, 1, 0, 4'hF, 32'h60C, 0, 0, 1));
      apply(mk(1, 32'h500, 1, 0, 4'hF, 32'h610, 0, 1, 0));
      apply(mk(1, 32'h504, 0, 0, 4'h0, 0, 0, 1, 0));
      apply(mk(1, 32'h508, 0, 0, 4'h0, 0, 0, 1, 0));
      apply(mk(1, 32'h50C, 0, 0, 4'h0, 0, 0, 1, 0));
`ifdef MEM_PORT_ARBITER_STATS_EN
      check("conflict_cnt1", 128'(cc1), 128'(5));
      check("conflict_cnt3", 128'(cc3), 128'(5));
`endif
      repeat (4) apply(idle);
      for (int k = 0; k < 4; k++) check({qn[k], "_leftover"}, 128'(q[k].size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the datapath's instruction-fetch port and its load/store port.
- Per cycle: picks one requester, drives the memory, and tracks in-flight reads so each fixed-latency read return is routed to its owner.
- Sits between the datapath (PC/fetch side and ALU-address/store side) and the memory macro.
- Generates the fetch-stall used to hold the PC.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MEM_LAT, 1, cycles from issue (mem_en high at a clock edge) to mem_rdata valid; legal range 1..4.
- MAX_STARVE, 4, consecutive denied fetch cycles before fetch is forced to win; 0 means data always wins.

Ports:
- rclk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch issued this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request.
- d_we  in  1  1 = store.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access issued this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after issue.
- if_stall  out  1  if_req & ~if_gnt.

Behaviour:
- **Grant (combinational, same cycle):**
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both: data wins unless MAX_STARVE>0 and starve_cnt >= MAX_STARVE, in which case fetch wins.
  - At most one gnt high per cycle. mem_en = if_gnt | d_gnt.
- **Memory drive:** mem_* carry the winner's fields. Fetch drives mem_we=0 and mem_be=all ones. When idle, mem_* are 0.
- **Request protocol:**
  - Requester holds req and its address/data stable until the cycle gnt is high.
  - A transaction completes at the edge where gnt is high. Requester may present a new request the next cycle.
- **starve_cnt** (width clog2(MAX_STARVE+1)):
  - Increments, saturating, each cycle if_req & ~if_gnt.
  - Clears on if_gnt or when if_req is low.
- **Owner pipeline:**
  - MEM_LAT-stage shift register of {valid, is_fetch}.
  - Stage 0 loads {1,1} on fetch grant, {1,0} on load grant, and {0,x} on a store or no grant.
  - When the last stage is valid, mem_rdata is steered to if_rdata or d_rdata. The matching rvalid is high for exactly that cycle; rdata outputs are 0 otherwise.
  - Throughput is one access per cycle. Up to MEM_LAT reads may be in flight.
- **Stores:** no rvalid; d_gnt is the completion.
- **Reset (rst low, async):**
  - Owner pipeline is cleared, starve_cnt=0.
  - if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, if_stall are 0; all data/address outputs are 0 while rst is low.
  - In-flight reads at reset assertion are dropped: no rvalid ever appears for them.
- **Same-cycle events:**
  - A return and a new grant in the same cycle are independent.
  - Back-to-back reads from the same owner return in issue order.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined:
  - Adds output conflict_cnt (32 bits), counting cycles with if_req & d_req both high.
  - Wraps at 2^32; reset to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: owner-tag encoding (OWN_FETCH=1, OWN_DATA=0), default MEM_LAT, and the byte-enable width constant.
- One natural sub-module, mem_owner_pipe: the MEM_LAT-deep {valid, is_fetch} shift register with async active-low clear.

Test Plan:
- Fetch only, MEM_LAT=1: if_req held with if_addr 0x0, 0x4, 0x8 → if_gnt=1 each cycle; if_rvalid one cycle after each grant carrying mem_rdata; if_stall=0.
- Conflict: if_req and d_req (load, 0x100) in the same cycle → d_gnt=1, if_gnt=0, if_stall=1. Next cycle (d_req low) → if_gnt=1. d_rvalid precedes if_rvalid by one cycle.
- Starvation, MAX_STARVE=4: d_req and if_req held 6 cycles → d_gnt in cycles 0–3, if_gnt in cycle 4, d_gnt in cycle 5.
- Store: d_we=1, d_be=0011, d_addr=0x200, d_wdata=0xDEADBEEF → mem_en=1, mem_we=1, mem_be=0011, mem_addr=0x200, mem_wdata=0xDEADBEEF; no d_rvalid.
- Reset mid-flight, MEM_LAT=3: fetch granted, then rst pulled low 1 cycle later and released → no if_rvalid in the following 5 cycles; all outputs 0 during reset.
- With MEM_PORT_ARBITER_STATS_EN: 5 cycles with both requests high, then 3 with only if_req → conflict_cnt=5.
